// File: rtl/deser_pkg.sv
// Shared types and helpers for the bit deserializer.
// PARITY state exists only when BIT_DESERIALIZER_PARITY_EN is defined.
package deser_pkg;

`ifdef BIT_DESERIALIZER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    // Number of bits needed to hold values 0..value-1; called as clog2(WIDTH+1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/deser_shift_core.sv
// Assembly shift register and bit counter for the deserializer.
// word_out is the word as it will look after this cycle's shift, or the held word when hold is set.
module deser_shift_core
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic             load,
    input  logic             shift,
    input  logic             hold,
    output logic [WIDTH-1:0] word_out,
    output logic             last
);
    localparam int CNT_W = clog2(WIDTH + 1);

    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] shift_word;
    logic [WIDTH-1:0] load_word;
    logic [CNT_W-1:0] cnt;

    always_comb begin
        load_word = '0;
        if (MSB_FIRST != 0) begin
            shift_word   = {word[WIDTH-2:0], d};
            load_word[0] = d;
        end else begin
            shift_word         = {d, word[WIDTH-1:1]};
            load_word[WIDTH-1] = d;
        end
    end

    assign last     = (cnt == CNT_W'(WIDTH - 1));
    assign word_out = hold ? word : shift_word;

    always_ff @(posedge clk) begin
        if (!reset) begin
            word <= '0;
            cnt  <= '0;
        end else if (load) begin
            word <= load_word;
            cnt  <= CNT_W'(1);
        end else if (shift) begin
            word <= shift_word;
            cnt  <= last ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/bit_deserializer.sv
// Serial-to-parallel deserializer: frame FSM, output register and valid/ready handshake.
// Define BIT_DESERIALIZER_PARITY_EN to append an even-parity bit per frame and expose parity_err.
module bit_deserializer
    import deser_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d,
    input  logic             bit_en,
    input  logic             sof,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overflow,
    output logic             busy
`ifdef BIT_DESERIALIZER_PARITY_EN
    ,
    output logic             parity_err
`endif
);
    state_t           state, state_n;
    logic             load, shift, complete, hold, last;
    logic [WIDTH-1:0] word_out;
`ifdef BIT_DESERIALIZER_PARITY_EN
    logic             perr_in;
    assign hold = (state == PARITY);
`else
    assign hold = 1'b0;
`endif

    deser_shift_core #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_core (
        .clk      (clk),
        .reset    (reset),
        .d        (d),
        .load     (load),
        .shift    (shift),
        .hold     (hold),
        .word_out (word_out),
        .last     (last)
    );

    always_comb begin
        state_n  = state;
        load     = 1'b0;
        shift    = 1'b0;
        complete = 1'b0;
`ifdef BIT_DESERIALIZER_PARITY_EN
        perr_in  = 1'b0;
`endif
        case (state)
            IDLE: if (bit_en && sof) begin
                load    = 1'b1;
                state_n = SHIFT;
            end
            SHIFT: if (bit_en) begin
                if (sof) begin
                    load = 1'b1;
                end else begin
                    shift = 1'b1;
                    if (last) begin
`ifdef BIT_DESERIALIZER_PARITY_EN
                        state_n = PARITY;
`else
                        complete = 1'b1;
                        state_n  = IDLE;
`endif
                    end
                end
            end
`ifdef BIT_DESERIALIZER_PARITY_EN
            PARITY: if (bit_en) begin
                if (sof) begin
                    load    = 1'b1;
                    state_n = SHIFT;
                end else begin
                    // Even parity: data plus parity bit must carry an even count of ones.
                    complete = 1'b1;
                    perr_in  = ^{word_out, d};
                    state_n  = IDLE;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
`ifdef BIT_DESERIALIZER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            overflow <= 1'b0;
            if (complete) begin
                // A consume on the same edge frees the register for the new word.
                if (!data_valid || data_ready) begin
                    data_out   <= word_out;
                    data_valid <= 1'b1;
`ifdef BIT_DESERIALIZER_PARITY_EN
                    parity_err <= perr_in;
`endif
                end else begin
                    overflow <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
`ifdef BIT_DESERIALIZER_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_bit_deserializer.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share serial stimulus;
// expected words are queued at stimulus time and popped by a monitor on each consume.
module tb_bit_deserializer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       d = 1'b0;
    logic       bit_en = 1'b0;
    logic       sof = 1'b0;
    logic       data_ready = 1'b1;
    logic [7:0] out0, out1;
    logic       v0, v1, ov0, ov1, b0, b1;
`ifdef BIT_DESERIALIZER_PARITY_EN
    logic       pe0, pe1;
`endif

    int errors = 0;
    int checks = 0;
    int ovf0 = 0;
    int ovf1 = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(1)) dut0 (
        .clk(clk), .reset(reset), .d(d), .bit_en(bit_en), .sof(sof),
        .data_ready(data_ready), .data_out(out0), .data_valid(v0),
        .overflow(ov0), .busy(b0)
`ifdef BIT_DESERIALIZER_PARITY_EN
        , .parity_err(pe0)
`endif
    );

    bit_deserializer #(.WIDTH(8), .MSB_FIRST(0)) dut1 (
        .clk(clk), .reset(reset), .d(d), .bit_en(bit_en), .sof(sof),
        .data_ready(data_ready), .data_out(out1), .data_valid(v1),
        .overflow(ov1), .busy(b1)
`ifdef BIT_DESERIALIZER_PARITY_EN
        , .parity_err(pe1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop and compare whenever a word is consumed.
    always @(negedge clk) begin
        if (reset && v0 && data_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb0_unexpected: got %0h expected no word", out0);
            end else check("sb0_word", {24'h0, out0}, {24'h0, q0.pop_front()});
        end
        if (reset && v1 && data_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL sb1_unexpected: got %0h expected no word", out1);
            end else check("sb1_word", {24'h0, out1}, {24'h0, q1.pop_front()});
        end
        if (ov0) ovf0++;
        if (ov1) ovf1++;
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        d = b; sof = s; bit_en = 1'b1;
        step();
        bit_en = 1'b0; sof = 1'b0; d = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], i == 7);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] w;
        // Reset with active inputs, which must be ignored.
        bit_en = 1'b1; sof = 1'b1; d = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state0", {21'h0, out0, v0, ov0, b0}, 32'h0);
        check("reset_state1", {21'h0, out1, v1, ov1, b1}, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1; bit_en = 1'b0; sof = 1'b0; d = 1'b0;

        // Basic frame, ready high: 0xB2 MSB-first, 0x4D LSB-first.
        q0.push_back(8'hB2); q1.push_back(8'h4D);
        w = 8'hB2;
        for (int i = 7; i >= 1; i--) send_bit(w[i], i == 7);
        check("t1_busy_mid", {31'h0, b0}, 32'h1);
        check("t1_no_valid_mid", {31'h0, v0}, 32'h0);
        send_bit(w[0], 1'b0);
        @(negedge clk);
        check("t1_valid", {31'h0, v0}, 32'h1);
        check("t1_word_msb", {24'h0, out0}, 32'hB2);
        check("t1_word_lsb", {24'h0, out1}, 32'h4D);
        check("t1_busy_done", {31'h0, b0}, 32'h0);
        @(negedge clk);
        check("t1_valid_one_cycle", {31'h0, v0}, 32'h0);

        // Overflow: ready low, 0xB2 held, 0x0F dropped.
        step(); data_ready = 1'b0;
        q0.push_back(8'hB2); q1.push_back(8'h4D);
        send_frame(8'hB2);
        send_frame(8'h0F);
        @(negedge clk);
        check("t2_ovf_pulse0", {31'h0, ov0}, 32'h1);
        check("t2_ovf_pulse1", {31'h0, ov1}, 32'h1);
        check("t2_held_msb", {24'h0, out0}, 32'hB2);
        check("t2_held_lsb", {24'h0, out1}, 32'h4D);
        @(negedge clk);
        check("t2_ovf_one_cycle", {31'h0, ov0}, 32'h0);
        check("t2_still_valid", {31'h0, v0}, 32'h1);
        step(); data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t2_consumed", {31'h0, v0}, 32'h0);

        // Restart: sof after 3 bits discards the partial frame.
        q0.push_back(8'hA5); q1.push_back(8'hA5);
        send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_frame(8'hA5);
        @(negedge clk);
        check("t3_word", {24'h0, out0}, 32'hA5);
        check("t3_no_ovf", {31'h0, ov0}, 32'h0);
        check("t3_ovf_count", ovf0, 32'd1);

        // Reset with a held word and a partial frame, then a clean frame.
        step(); data_ready = 1'b0;
        send_frame(8'h55);
        send_bit(1'b0, 1'b1); send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        @(negedge clk);
        check("t4_busy_pre", {31'h0, b0}, 32'h1);
        check("t4_held_pre", {31'h0, v0}, 32'h1);
        step();
        reset = 1'b0; bit_en = 1'b1; sof = 1'b1; d = 1'b1;
        step();
        reset = 1'b1; bit_en = 1'b0; sof = 1'b0; d = 1'b0;
        @(negedge clk);
        check("t4_after_reset0", {21'h0, out0, v0, ov0, b0}, 32'h0);
        check("t4_after_reset1", {21'h0, out1, v1, ov1, b1}, 32'h0);
        step(); data_ready = 1'b1;
        q0.push_back(8'h3C); q1.push_back(8'h3C);
        send_frame(8'h3C);
        @(negedge clk);
        check("t4_word_msb", {24'h0, out0}, 32'h3C);
        check("t4_word_lsb", {24'h0, out1}, 32'h3C);

        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);
        check("ovf0_total", ovf0, 32'd1);
        check("ovf1_total", ovf1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
